// File: rtl/crack_scheduler_if.sv
// Bus bundle between the key-search scheduler, its crack engines and the
// shared ciphertext memory.
//
// Handshakes:
//  - en/rdy: a start request is taken on the rising edge at which en & rdy
//    are both high; en while rdy is low has no effect. The requester does
//    not need to hold en after that edge.
//  - eng_ct_req/eng_ct_gnt: an engine raises req with a stable addr and
//    keeps both unchanged until the cycle in which gnt is high. The read
//    completes with eng_ct_rvalid high one cycle after the grant.
interface crack_scheduler_if #(
  parameter int NUM_ENGINES = 2,
  parameter int KEY_W       = 24
);
  logic                         en;
  logic                         rdy;
  logic [KEY_W-1:0]             key;
  logic                         key_valid;
  logic                         done;
  logic [NUM_ENGINES-1:0]       eng_rst_n;
  logic [NUM_ENGINES-1:0]       eng_en;
  logic [NUM_ENGINES-1:0]       eng_rdy;
  logic [NUM_ENGINES-1:0]       eng_key_valid;
  logic [NUM_ENGINES-1:0]       eng_exhausted;
  logic [NUM_ENGINES*KEY_W-1:0] eng_key;
  logic [NUM_ENGINES-1:0]       eng_ct_req;
  logic [NUM_ENGINES*8-1:0]     eng_ct_addr;
  logic [NUM_ENGINES-1:0]       eng_ct_gnt;
  logic [NUM_ENGINES-1:0]       eng_ct_rvalid;
  logic [7:0]                   eng_ct_rddata;
  logic [7:0]                   ct_addr;
  logic [7:0]                   ct_rddata;

  // Scheduler side
  modport slave (
    input  en, eng_rdy, eng_key_valid, eng_exhausted, eng_key,
           eng_ct_req, eng_ct_addr, ct_rddata,
    output rdy, key, key_valid, done, eng_rst_n, eng_en,
           eng_ct_gnt, eng_ct_rvalid, eng_ct_rddata, ct_addr
  );

  // Host, engines and memory side
  modport master (
    output en, eng_rdy, eng_key_valid, eng_exhausted, eng_key,
           eng_ct_req, eng_ct_addr, ct_rddata,
    input  rdy, key, key_valid, done, eng_rst_n, eng_en,
           eng_ct_gnt, eng_ct_rvalid, eng_ct_rddata, ct_addr
  );
endinterface

// File: rtl/crack_scheduler.sv
// Parallel ARC4 key-search controller: sequences the engines through reset,
// start and run, round-robin arbitrates the shared ciphertext read port and
// latches the key of the lowest-index engine that reports a hit.
module crack_scheduler #(
  parameter int NUM_ENGINES = 2,
  parameter int KEY_W       = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  crack_scheduler_if.slave     bus,
  output logic [2:0]           dbg_state
);

  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RELEASE, S_WAIT_RDY, S_START, S_RUN, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic                   key_valid_q, key_valid_d;
  logic                   done_q, done_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [7:0]             ct_addr_q, ct_addr_d;
  logic [NUM_ENGINES-1:0] rvalid_q, rvalid_d;
  logic [NUM_ENGINES-1:0] gnt;
  logic                   arb_en;
  logic                   win_found;
  logic [KEY_W-1:0]       win_key;

  // Lowest-index engine reporting a valid key wins.
  always_comb begin
    win_found = 1'b0;
    win_key   = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (bus.eng_key_valid[i]) begin
        win_found = 1'b1;
        win_key   = bus.eng_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Next state and result registers; a hit outranks exhaustion and arbitration.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    done_d      = done_q;
    arb_en      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.en) begin
          state_d     = S_RELEASE;
          key_d       = '0;
          key_valid_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      S_RELEASE:  state_d = S_WAIT_RDY;
      S_WAIT_RDY: if (&bus.eng_rdy) state_d = S_START;
      S_START:    state_d = S_RUN;
      S_RUN: begin
        if (win_found) begin
          state_d     = S_DONE;
          key_d       = win_key;
          key_valid_d = 1'b1;
          done_d      = 1'b1;
        end else if (&bus.eng_exhausted) begin
          state_d     = S_DONE;
          key_d       = '0;
          key_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          arb_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round-robin grant: scan from the pointer, first requester wins.
  always_comb begin
    int idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    gnt       = '0;
    ptr_d     = ptr_q;
    ct_addr_d = ct_addr_q;
    if (arb_en) begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        idx = (int'(ptr_q) + k) % NUM_ENGINES;
        if (!found && bus.eng_ct_req[idx]) begin
          found     = 1'b1;
          gnt[idx]  = 1'b1;
          ct_addr_d = bus.eng_ct_addr[idx*8 +: 8];
          ptr_d     = PTR_W'((idx + 1) % NUM_ENGINES);
        end
      end
    end
    rvalid_d = gnt;
  end

  // State, result, pointer and read-pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ptr_q       <= '0;
      ct_addr_q   <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      ptr_q       <= ptr_d;
      ct_addr_q   <= ct_addr_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign bus.rdy           = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.key           = key_q;
  assign bus.key_valid     = key_valid_q;
  assign bus.done          = done_q;
  assign bus.eng_rst_n     = (state_q inside {S_RELEASE, S_WAIT_RDY, S_START, S_RUN})
                             ? '1 : '0;
  assign bus.eng_en        = (state_q == S_START) ? '1 : '0;
  assign bus.eng_ct_gnt    = gnt;
  assign bus.eng_ct_rvalid = rvalid_q;
  assign bus.eng_ct_rddata = bus.ct_rddata;
  assign bus.ct_addr       = ct_addr_d;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// Self-checking bench for crack_scheduler with two engines.
module tb_crack_scheduler;

  localparam int N  = 2;
  localparam int KW = 24;
  localparam int W  = N + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  crack_scheduler_if #(.NUM_ENGINES(N), .KEY_W(KW)) bus ();

  crack_scheduler #(.NUM_ENGINES(N), .KEY_W(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  logic [7:0] ct_mem [256];
  always @(posedge clk) bus.ct_rddata <= ct_mem[bus.ct_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]    pend;
  logic [7:0]      paddr [N];
  logic [N-1:0]    kv_in, exh_in;
  logic [N*KW-1:0] key_in;
  int              m_ptr;
  logic [W-1:0]    exp_q [$];

  typedef struct {
    logic [N-1:0]  kv;
    logic [N-1:0]  exh;
    logic [N-1:0]  req;
    logic [KW-1:0] k0;
    logic [KW-1:0] k1;
    logic          exp_done;
    logic          exp_kv;
    logic [KW-1:0] exp_key;
  } vec_t;

  vec_t vecs [7];

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_inputs();
    bus.eng_ct_req    = pend;
    for (int i = 0; i < N; i++) bus.eng_ct_addr[i*8 +: 8] = paddr[i];
    bus.eng_key_valid = kv_in;
    bus.eng_exhausted = exh_in;
    bus.eng_key       = key_in;
  endtask

  task automatic idle_inputs();
    pend    = '0;
    kv_in   = '0;
    exh_in  = '0;
    key_in  = '0;
    for (int i = 0; i < N; i++) paddr[i] = 8'h00;
    bus.eng_rdy = '0;
    drive_inputs();
  endtask

  // From IDLE/DONE at a negedge: accept en, walk RELEASE/WAIT_RDY/START, land in RUN.
  task automatic start_search();
    bus.en = 1'b1;
    tick();
    check("release_rdy", bus.rdy, 1'b0);
    check("release_rst_n", bus.eng_rst_n, {N{1'b1}});
    check("release_done", bus.done, 1'b0);
    check("release_key_valid", bus.key_valid, 1'b0);
    check("release_key", bus.key, '0);
    check("release_eng_en", bus.eng_en, '0);
    tick();  // en still high while busy: must be ignored
    check("wait_rdy_busy", bus.rdy, 1'b0);
    check("wait_rdy_eng_en", bus.eng_en, '0);
    bus.en      = 1'b0;
    bus.eng_rdy = '1;
    tick();
    check("start_eng_en", bus.eng_en, {N{1'b1}});
    tick();
    check("run_eng_en_low", bus.eng_en, '0);
    check("run_rst_n", bus.eng_rst_n, {N{1'b1}});
  endtask

  // One RUN cycle checked against the reference model; ends at the next negedge.
  task automatic arb_cycle();
    logic [N-1:0] eg;
    logic [W-1:0] got;
    int g;
    drive_inputs();
    #1;
    eg = '0;
    g  = -1;
    if (kv_in == '0 && exh_in != {N{1'b1}}) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    if (g >= 0) eg[g] = 1'b1;
    check("gnt", bus.eng_ct_gnt, eg);
    if (g >= 0) begin
      check("ct_addr", bus.ct_addr, paddr[g]);
      exp_q.push_back({eg, ct_mem[paddr[g]]});
      m_ptr   = (g + 1) % N;
      pend[g] = 1'b0;
    end else begin
      exp_q.push_back('0);
    end
    tick();
    got = {bus.eng_ct_rvalid, (bus.eng_ct_rvalid != '0) ? bus.eng_ct_rddata : 8'h00};
    check("rvalid_data", got, exp_q.pop_front());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [KW-1:0] ek;
    logic          found;
    int            nc;
    int            seq [4];

    for (int i = 0; i < 256; i++) ct_mem[i] = 8'($urandom);
    ct_mem[8'h00] = 8'h0A;
    ct_mem[8'h05] = 8'h41;
    bus.en = 1'b0;
    idle_inputs();
    m_ptr = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdy", bus.rdy, 1'b1);
    check("reset_key", bus.key, '0);
    check("reset_key_valid", bus.key_valid, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_rst_n", bus.eng_rst_n, '0);
    check("reset_eng_en", bus.eng_en, '0);
    check("reset_gnt", bus.eng_ct_gnt, '0);
    check("reset_rvalid", bus.eng_ct_rvalid, '0);
    check("reset_ct_addr", bus.ct_addr, 8'h00);
    rst = 1'b0;
    tick();
    check("idle_rdy", bus.rdy, 1'b1);

    // Table-driven completion vectors
    vecs[0] = '{kv:2'b10, exh:2'b00, req:2'b11, k0:24'h000000, k1:24'h0001F3, exp_done:1, exp_kv:1, exp_key:24'h0001F3};
    vecs[1] = '{kv:2'b11, exh:2'b00, req:2'b11, k0:24'h000010, k1:24'h000011, exp_done:1, exp_kv:1, exp_key:24'h000010};
    vecs[2] = '{kv:2'b00, exh:2'b11, req:2'b11, k0:24'h000777, k1:24'h000888, exp_done:1, exp_kv:0, exp_key:24'h000000};
    vecs[3] = '{kv:2'b10, exh:2'b11, req:2'b00, k0:24'h000001, k1:24'hABCDEF, exp_done:1, exp_kv:1, exp_key:24'hABCDEF};
    vecs[4] = '{kv:2'b01, exh:2'b00, req:2'b10, k0:24'h123456, k1:24'h654321, exp_done:1, exp_kv:1, exp_key:24'h123456};
    vecs[5] = '{kv:2'b00, exh:2'b01, req:2'b00, k0:24'h111111, k1:24'h222222, exp_done:0, exp_kv:0, exp_key:24'h000000};
    vecs[6] = '{kv:2'b00, exh:2'b10, req:2'b00, k0:24'h333333, k1:24'h444444, exp_done:0, exp_kv:0, exp_key:24'h000000};

    for (int v = 0; v < 7; v++) begin
      start_search();
      repeat (2) tick();
      pend   = vecs[v].req;
      kv_in  = vecs[v].kv;
      exh_in = vecs[v].exh;
      key_in = {vecs[v].k1, vecs[v].k0};
      drive_inputs();
      #1;
      check($sformatf("vec%0d_no_gnt", v), bus.eng_ct_gnt, '0);
      tick();
      check($sformatf("vec%0d_done", v), bus.done, vecs[v].exp_done);
      check($sformatf("vec%0d_key_valid", v), bus.key_valid, vecs[v].exp_kv);
      check($sformatf("vec%0d_key", v), bus.key, vecs[v].exp_key);
      check($sformatf("vec%0d_rdy", v), bus.rdy, vecs[v].exp_done);
      check($sformatf("vec%0d_rst_n", v), bus.eng_rst_n, vecs[v].exp_done ? 2'b00 : 2'b11);
      if (!vecs[v].exp_done) begin
        kv_in  = '0;
        exh_in = '1;
        drive_inputs();
        tick();
        check($sformatf("vec%0d_exhaust_done", v), bus.done, 1'b1);
      end
      idle_inputs();
      tick();
    end

    // Directed arbitration: both engines request continuously
    start_search();
    seq = '{0, 1, 0, 1};
    paddr[0] = 8'h00;
    paddr[1] = 8'h05;
    pend = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive_inputs();
      #1;
      check($sformatf("arb%0d_gnt", i), bus.eng_ct_gnt, 2'b01 << seq[i]);
      check($sformatf("arb%0d_ct_addr", i), bus.ct_addr, seq[i] ? 8'h05 : 8'h00);
      tick();
      check($sformatf("arb%0d_rvalid", i), bus.eng_ct_rvalid, 2'b01 << seq[i]);
      check($sformatf("arb%0d_rddata", i), bus.eng_ct_rddata, seq[i] ? 8'h41 : 8'h0A);
    end

    // Reset mid-RUN: leave pointer at 1, then reset while requests are live
    drive_inputs();
    #1;
    check("pre_rst_gnt", bus.eng_ct_gnt, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rdy", bus.rdy, 1'b1);
    check("midrst_gnt", bus.eng_ct_gnt, '0);
    check("midrst_rvalid", bus.eng_ct_rvalid, '0);
    check("midrst_rst_n", bus.eng_rst_n, '0);
    check("midrst_state_idle", dbg_state, 3'd0);
    check("midrst_done", bus.done, 1'b0);
    idle_inputs();
    m_ptr = 0;
    exp_q.delete();
    tick();
    check("midrst_hold_rvalid", bus.eng_ct_rvalid, '0);
    start_search();
    paddr[0] = 8'h00;
    paddr[1] = 8'h05;
    pend = 2'b11;
    repeat (3) begin
      arb_cycle();
      for (int i = 0; i < N; i++) if (!pend[i]) pend[i] = 1'b1;
    end
    exh_in = '1;
    arb_cycle();
    check("midrst_exh_done", bus.done, 1'b1);
    check("midrst_exh_key_valid", bus.key_valid, 1'b0);
    idle_inputs();
    tick();

    // Randomized searches against the reference model
    for (int s = 0; s < 6; s++) begin
      start_search();
      nc = $urandom_range(20, 60);
      for (int c = 0; c < nc; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(0, 3) != 0) begin
            pend[i]  = 1'b1;
            paddr[i] = 8'($urandom);
          end
        end
        exh_in = N'($urandom_range(0, (1 << N) - 2));
        arb_cycle();
        check("rand_running_done", bus.done, 1'b0);
      end
      key_in = {N*KW{1'b0}};
      for (int i = 0; i < N; i++) key_in[i*KW +: KW] = KW'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        kv_in  = N'($urandom_range(1, (1 << N) - 1));
        exh_in = N'($urandom_range(0, (1 << N) - 1));
      end else begin
        kv_in  = '0;
        exh_in = '1;
      end
      found = 1'b0;
      ek    = '0;
      for (int i = 0; i < N; i++) begin
        if (!found && kv_in[i]) begin
          found = 1'b1;
          ek    = key_in[i*KW +: KW];
        end
      end
      arb_cycle();
      check("rand_done", bus.done, 1'b1);
      check("rand_key_valid", bus.key_valid, found);
      check("rand_key", bus.key, ek);
      check("rand_rdy", bus.rdy, 1'b1);
      check("rand_rst_n", bus.eng_rst_n, '0);
      idle_inputs();
      tick();
      check("rand_done_hold", bus.done, 1'b1);
      check("rand_key_hold", bus.key, ek);
      check("rand_rvalid_quiet", bus.eng_ct_rvalid, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
